// File: rtl/alu_rs_if.sv
// Dispatch, broadcast and issue signals of the ALU reservation station.
// master = dispatcher/CDB/ALU side, slave = the reservation station.
interface alu_rs_if #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4,
  parameter int NAME_W = 5,
  parameter int OP_W   = 6,
  parameter int ADDR_W = 32
);
  logic              flush;
  logic              dispEn;
  logic [OP_W-1:0]   dispOp;
  logic [DATA_W-1:0] dispValO;
  logic [DATA_W-1:0] dispValT;
  logic [TAG_W-1:0]  dispTagO;
  logic [TAG_W-1:0]  dispTagT;
  logic [TAG_W-1:0]  dispWrtTag;
  logic [NAME_W-1:0] dispWrtName;
  logic [ADDR_W-1:0] dispAddr;
  logic              rsFull;
  logic              cdbAEn;
  logic [TAG_W-1:0]  cdbATag;
  logic [DATA_W-1:0] cdbAData;
  logic              cdbBEn;
  logic [TAG_W-1:0]  cdbBTag;
  logic [DATA_W-1:0] cdbBData;
  logic              ALUworkEn;
  logic [DATA_W-1:0] operandO;
  logic [DATA_W-1:0] operandT;
  logic [TAG_W-1:0]  wrtTag;
  logic [NAME_W-1:0] wrtName;
  logic [OP_W-1:0]   opCode;
  logic [ADDR_W-1:0] instAddr;

  modport master (
    output flush, dispEn, dispOp, dispValO, dispValT, dispTagO, dispTagT,
           dispWrtTag, dispWrtName, dispAddr,
           cdbAEn, cdbATag, cdbAData, cdbBEn, cdbBTag, cdbBData,
    input  rsFull, ALUworkEn, operandO, operandT, wrtTag, wrtName, opCode, instAddr
  );

  modport slave (
    input  flush, dispEn, dispOp, dispValO, dispValT, dispTagO, dispTagT,
           dispWrtTag, dispWrtName, dispAddr,
           cdbAEn, cdbATag, cdbAData, cdbBEn, cdbBTag, cdbBData,
    output rsFull, ALUworkEn, operandO, operandT, wrtTag, wrtName, opCode, instAddr
  );
endinterface

// File: rtl/alu_rs.sv
// ALU reservation station: DEPTH entries, operand wake-up from two result
// buses, lowest-index-ready select into a registered one-per-cycle issue port.
module alu_rs #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4,
  parameter int NAME_W = 5,
  parameter int OP_W   = 6,
  parameter int ADDR_W = 32
) (
  input logic     clk,
  input logic     rst,
  alu_rs_if.slave rs
);
  localparam int IDX_W = $clog2(DEPTH);

  // Entry control state (reset) and payload (not reset)
  logic [DEPTH-1:0] busy;
  logic [TAG_W-1:0]  tag_o   [DEPTH];
  logic [TAG_W-1:0]  tag_t   [DEPTH];
  logic [DATA_W-1:0] val_o   [DEPTH];
  logic [DATA_W-1:0] val_t   [DEPTH];
  logic [OP_W-1:0]   op_q    [DEPTH];
  logic [TAG_W-1:0]  wtag_q  [DEPTH];
  logic [NAME_W-1:0] wname_q [DEPTH];
  logic [ADDR_W-1:0] addr_q  [DEPTH];

  // Issue registers
  logic              iss_en;
  logic [DATA_W-1:0] iss_o;
  logic [DATA_W-1:0] iss_t;
  logic [TAG_W-1:0]  iss_wtag;
  logic [NAME_W-1:0] iss_wname;
  logic [OP_W-1:0]   iss_op;
  logic [ADDR_W-1:0] iss_addr;

  logic              a_en, b_en;
  logic [TAG_W-1:0]  a_tag, b_tag;
  logic [DATA_W-1:0] a_data, b_data;

  assign a_en   = rs.cdbAEn;
  assign a_tag  = rs.cdbATag;
  assign a_data = rs.cdbAData;
  assign b_en   = rs.cdbBEn;
  assign b_tag  = rs.cdbBTag;
  assign b_data = rs.cdbBData;

  // A waiting tag is satisfied by either bus; tag 0 never matches.
  function automatic logic hit(input logic [TAG_W-1:0] t);
    return (t != '0) && ((a_en && t == a_tag) || (b_en && t == b_tag));
  endfunction

  // Bus A wins when both buses carry the same tag.
  function automatic logic [DATA_W-1:0] pick(input logic [TAG_W-1:0] t);
    return (a_en && t == a_tag) ? a_data : b_data;
  endfunction

  logic [DEPTH-1:0] ready;
  logic             free_vld, sel_vld, do_disp;
  logic [IDX_W-1:0] free_idx, sel_idx;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    free_vld = 1'b0;
    free_idx = '0;
    sel_vld  = 1'b0;
    sel_idx  = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      ready[i] = busy[i] && (tag_o[i] == '0) && (tag_t[i] == '0);
      if (!busy[i]) begin
        free_vld = 1'b1;
        free_idx = IDX_W'(i);
      end
      if (ready[i]) begin
        sel_vld = 1'b1;
        sel_idx = IDX_W'(i);
      end
    end
  end

  assign do_disp = rs.dispEn && free_vld && !rs.flush;

  // NOTE: state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tag_o[i] <= '0;
        tag_t[i] <= '0;
      end
      iss_en    <= 1'b0;
      iss_o     <= '0;
      iss_t     <= '0;
      iss_wtag  <= '0;
      iss_wname <= '0;
      iss_op    <= '0;
      iss_addr  <= '0;
    end else if (rs.flush) begin
      busy      <= '0;
      iss_en    <= 1'b0;
      iss_o     <= '0;
      iss_t     <= '0;
      iss_wtag  <= '0;
      iss_wname <= '0;
      iss_op    <= '0;
      iss_addr  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (busy[i] && hit(tag_o[i])) tag_o[i] <= '0;
        if (busy[i] && hit(tag_t[i])) tag_t[i] <= '0;
      end
      iss_en <= sel_vld;
      if (sel_vld) begin
        busy[sel_idx] <= 1'b0;
        iss_o         <= val_o[sel_idx];
        iss_t         <= val_t[sel_idx];
        iss_wtag      <= wtag_q[sel_idx];
        iss_wname     <= wname_q[sel_idx];
        iss_op        <= op_q[sel_idx];
        iss_addr      <= addr_q[sel_idx];
      end else begin
        iss_o     <= '0;
        iss_t     <= '0;
        iss_wtag  <= '0;
        iss_wname <= '0;
        iss_op    <= '0;
        iss_addr  <= '0;
      end
      // The free slot is never the selected one: free is idle, selected is busy.
      if (do_disp) begin
        busy[free_idx]  <= 1'b1;
        tag_o[free_idx] <= hit(rs.dispTagO) ? '0 : rs.dispTagO;
        tag_t[free_idx] <= hit(rs.dispTagT) ? '0 : rs.dispTagT;
      end
    end
  end

  // NOTE: payload storage has no reset; busy and the zeroed tags decide validity.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (!rs.flush && busy[i] && hit(tag_o[i])) val_o[i] <= pick(tag_o[i]);
      if (!rs.flush && busy[i] && hit(tag_t[i])) val_t[i] <= pick(tag_t[i]);
    end
    if (do_disp) begin
      val_o[free_idx]   <= hit(rs.dispTagO) ? pick(rs.dispTagO) : rs.dispValO;
      val_t[free_idx]   <= hit(rs.dispTagT) ? pick(rs.dispTagT) : rs.dispValT;
      op_q[free_idx]    <= rs.dispOp;
      wtag_q[free_idx]  <= rs.dispWrtTag;
      wname_q[free_idx] <= rs.dispWrtName;
      addr_q[free_idx]  <= rs.dispAddr;
    end
  end

  assign rs.rsFull    = &busy;
  assign rs.ALUworkEn = iss_en;
  assign rs.operandO  = iss_o;
  assign rs.operandT  = iss_t;
  assign rs.wrtTag    = iss_wtag;
  assign rs.wrtName   = iss_wname;
  assign rs.opCode    = iss_op;
  assign rs.instAddr  = iss_addr;
endmodule

// File: doc/alu_rs.md
# alu_rs

Reservation station for the ALU. Holds up to DEPTH dispatched integer/branch-class instructions, captures missing operands from two result broadcast buses, and issues one ready instruction per cycle to the ALU through a registered issue port. Sits between the dispatcher (upstream) and the ALU (downstream). The ALU's ROB write-back is one of the two wake-up buses.

## Interface
- DEPTH, 8: number of entries (power of two, 2..16)
- DATA_W, 32: operand/result width
- TAG_W, 4: ROB tag width; tag value 0 means "no dependency / value present"
- NAME_W, 5: destination register name width
- OP_W, 6: opcode width
- ADDR_W, 32: instruction address width

- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- flush  in  1  sync clear of all entries (misprediction)
- dispEn  in  1  dispatch strobe
- dispOp  in  OP_W  opcode
- dispValO / dispValT  in  DATA_W  operand values (valid when matching tag is 0)
- dispTagO / dispTagT  in  TAG_W  producer tags (0 = ready)
- dispWrtTag  in  TAG_W  ROB tag of this instruction
- dispWrtName  in  NAME_W  destination name
- dispAddr  in  ADDR_W  instruction address
- rsFull  out  1  all entries occupied
- cdbAEn / cdbBEn  in  1  broadcast valid (A = ALU, B = load/store)
- cdbATag / cdbBTag  in  TAG_W  broadcast tag
- cdbAData / cdbBData  in  DATA_W  broadcast data
- ALUworkEn  out  1  issue valid (one cycle)
- operandO / operandT  out  DATA_W  issued operands
- wrtTag  out  TAG_W;  wrtName  out  NAME_W;  opCode  out  OP_W;  instAddr  out  ADDR_W

## Operation
- Entry state: busy, op, valO, valT, tagO, tagT, wrtTag, wrtName, addr. Entry ready = busy & tagO==0 & tagT==0.
- Dispatch: when dispEn & !rsFull & !flush, write into the lowest-index non-busy entry (as of start of cycle). dispEn while rsFull is ignored (no write, no error).
- Dispatch bypass: if a dispatched operand tag is nonzero and equals an enabled broadcast tag in the same cycle, store the broadcast data and tag 0.
- Wake-up: every busy entry operand with nonzero tag matching cdbATag (cdbAEn) or cdbBTag (cdbBEn) captures that data and clears its tag. Broadcast tag 0 is never matched. If both buses carry the same tag, bus A wins.
- Select: lowest-index ready entry, evaluated on registered state. Selected entry is cleared (busy=0) at the clock edge and its fields loaded into the issue registers; ALUworkEn=1 for that cycle only.
- No ready entry: ALUworkEn=0; other issue outputs hold 0.
- Dispatch and issue in the same cycle: both occur; the slot freed by issue is not usable by that cycle's dispatch.
- rsFull = all DEPTH busy bits set (from registered state).
- flush: at the edge, clear all busy bits and ALUworkEn; dispatch, wake-up and issue in that cycle are discarded. Flush has priority over everything.

## Timing
- Reset (async, rst=0): all busy=0, all tags 0, ALUworkEn=0, operandO/T=0, wrtTag=0, wrtName=0, opCode=0, instAddr=0, rsFull=0. Deassertion mid-operation starts from this empty state.
- Dispatch of a ready instruction into an empty RS at edge N: ALUworkEn=1 after edge N+1 (1 cycle in RS, then registered issue).
- Operand woken by broadcast sampled at edge N: entry eligible for select in cycle after N; issued at edge N+1.
- Dispatch with same-cycle matching broadcast: treated as ready, same latency as ready dispatch.
- Throughput: one issue per cycle; one dispatch per cycle.
- rsFull updates the cycle after the filling dispatch; falls the cycle after an issue from a full RS.

## Test plan
- Reset then dispatch ADD, valO=5, valT=7, tags 0, wrtTag=3 -> one cycle later ALUworkEn=1, operandO=5, operandT=7, wrtTag=3; next cycle ALUworkEn=0.
- Dispatch op with tagO=4 (dependent) -> no issue; cdbAEn with tag 4, data 0x10 -> issue next edge with operandO=0x10.
- Dispatch with tagT=6 while cdbBEn tag 6 data 0xFF same cycle -> issued next cycle with operandT=0xFF.
- Fill 8 dependent entries -> rsFull=1; 9th dispEn ignored; broadcast wakes entry 2 -> entry 2 issues, rsFull drops, next dispatch lands in entry 2.
- Three ready entries at indices 1,3,5 -> issue order 1,3,5 on consecutive cycles.
- Four busy entries, flush -> next cycle ALUworkEn=0, rsFull=0, no later issue; assert rst mid-issue -> all outputs 0 immediately.
